// File: rtl/logic_gate_pkg.sv
//==============================================================================
// Module   : logic_gate_pkg
// Purpose  : Op encoding and FSM state encoding shared by the logic gate unit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/logic_gate_core.sv
//==============================================================================
// Module   : logic_gate_core
// Purpose  : Combinational WIDTH-bit gate mux; unary ops act on x.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    always_comb begin
        f = x;
        case (op)
            OP_AND:  f = x & y;
            OP_OR:   f = x | y;
            OP_NAND: f = ~(x & y);
            OP_NOR:  f = ~(x | y);
            OP_XOR:  f = x ^ y;
            OP_XNOR: f = ~(x ^ y);
            OP_NOT:  f = ~x;
            default: f = x;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic_gate_unit.sv
//==============================================================================
// Module   : logic_gate_unit
// Purpose  : Registered bitwise gate unit with left-fold bursts and valid/ready.
//            Optional zero/parity outputs under LOGIC_GATE_UNIT_FLAGS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    output logic             zero,
    output logic             parity,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_bcnt;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;

    logic             w_fire;
    logic             w_in_accum;
    logic [WIDTH-1:0] w_f;
    logic [CNT_W-1:0] w_bcnt_inc;
    logic             w_load;
    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;

    assign in_ready   = !r_out_valid | out_ready;
    assign w_fire     = in_valid & in_ready;
    assign w_in_accum = (r_state == ST_ACCUM);
    assign w_bcnt_inc = (r_bcnt == c_CNT_MAX) ? r_bcnt : r_bcnt + c_CNT_ONE;

    // All binary ops are commutative, so the newest A always sits on x; that
    // makes NOT/BUF in a fold act on the newest operand.
    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .x  (A),
        .y  (w_in_accum ? r_acc : B),
        .op (w_in_accum ? r_op  : op),
        .f  (w_f)
    );

    always_comb begin
        w_load     = 1'b0;
        w_q_next   = w_f;
        w_cnt_next = c_CNT_ONE;
        if (w_fire) begin
            if (w_in_accum) begin
                w_load     = last;
                w_cnt_next = w_bcnt_inc;
            end else if (!acc) begin
                w_load = 1'b1;
            end else if (last) begin
                w_load   = 1'b1;
                w_q_next = A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_AND;
            r_acc       <= '0;
            r_bcnt      <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load) begin
                r_q         <= w_q_next;
                r_cnt       <= w_cnt_next;
                r_out_valid <= 1'b1;
            end
            if (w_fire) begin
                case (r_state)
                    ST_IDLE: begin
                        if (acc && !last) begin
                            r_acc   <= A;
                            r_bcnt  <= c_CNT_ONE;
                            r_op    <= op;
                            r_state <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        r_acc  <= w_f;
                        r_bcnt <= w_bcnt_inc;
                        if (last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign Q         = r_q;
    assign cnt       = r_cnt;

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic r_zero;
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_zero   <= ~|w_q_next;
            r_parity <= ^w_q_next;
        end
    end

    assign zero   = r_zero;
    assign parity = r_parity;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
//==============================================================================
// Module   : tb_logic_gate_unit
// Purpose  : Scoreboard bench for logic_gate_unit (WIDTH=8, CNT_W=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_logic_gate_unit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             acc;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic [CNT_W-1:0] cnt;
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic             zero;
    logic             parity;
`endif

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .acc       (acc),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        .zero      (zero),
        .parity    (parity),
`endif
        .Q         (Q),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t             sb[$];
    exp_t             m_e;
    int               checks = 0;
    int               errors = 0;

    // reference model state
    bit               in_burst = 0;
    logic [2:0]       bop;
    logic [WIDTH-1:0] bq[$];

    function automatic logic [WIDTH-1:0] gate(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic push(input logic [WIDTH-1:0] q, input int n);
        exp_t e;
        e.q = q;
        e.c = CNT_W'((n > CMAX) ? CMAX : n);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Offer one beat until accepted, randomising out_ready each cycle; then update model.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] o,
                        input bit ac, input bit ls, input int rdy_pct);
        bit got = 0;
        logic [WIDTH-1:0] v;
        in_valid = 1'b1; A = a; B = b; op = o; acc = ac; last = ls;
        for (int t = 0; t < 100 && !got; t++) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 100 cycles");
            return;
        end
        if (!in_burst) begin
            if (!ac) push(gate(o, a, b), 1);
            else if (ls) push(a, 1);
            else begin in_burst = 1; bop = o; bq = {a}; end
        end else begin
            bq.push_back(a);
            if (ls) begin
                v = bq[0];
                for (int i = 1; i < bq.size(); i++)
                    v = (bop >= 3'd6) ? gate(bop, bq[i], v) : gate(bop, v, bq[i]);
                push(v, bq.size());
                in_burst = 0;
            end
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out: out_valid=1 Q=%0h, expected no result pending", Q);
            end else if (out_ready) begin
                m_e = sb.pop_front();
                checks++;
                if (Q !== m_e.q || cnt !== m_e.c) begin
                    errors++;
                    $display("FAIL result: Q=%0h cnt=%0d, expected Q=%0h cnt=%0d", Q, cnt, m_e.q, m_e.c);
                end
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
                checks++;
                if (zero !== ~|m_e.q || parity !== ^m_e.q) begin
                    errors++;
                    $display("FAIL flags: zero=%0b parity=%0b, expected zero=%0b parity=%0b",
                             zero, parity, ~|m_e.q, ^m_e.q);
                end
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; op = '0; acc = 1'b0; last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_q", 32'(Q), 0);
        chk("reset_cnt", 32'(cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // single AND then backpressure
        send(8'hF0, 8'h3C, 3'd0, 0, 0, 0);
        @(negedge clk);
        chk("and_valid", 32'(out_valid), 1);
        chk("and_q", 32'(Q), 32'h30);
        chk("and_cnt", 32'(cnt), 1);
        @(posedge clk); #1;
        in_valid = 1'b1; A = 8'hFF; B = 8'h00; op = 3'd1; acc = 1'b0; last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_q_hold", 32'(Q), 32'h30);
            @(posedge clk); #1;
        end
        send(8'hFF, 8'h00, 3'd1, 0, 0, 100);
        @(negedge clk);
        chk("or_q", 32'(Q), 32'hFF);
        @(posedge clk); #1;

        // XOR burst
        send(8'h01, 8'h00, 3'd4, 1, 0, 100);
        @(negedge clk); chk("burst_no_out1", 32'(out_valid), 0); @(posedge clk); #1;
        send(8'h02, 8'h00, 3'd4, 1, 0, 100);
        @(negedge clk); chk("burst_no_out2", 32'(out_valid), 0); @(posedge clk); #1;
        send(8'h04, 8'h00, 3'd4, 1, 1, 100);
        @(negedge clk);
        chk("xor_valid", 32'(out_valid), 1);
        chk("xor_q", 32'(Q), 32'h07);
        chk("xor_cnt", 32'(cnt), 3);
        @(posedge clk); #1;

        // latched op + saturating count
        send(8'hFF, 8'h00, 3'd0, 1, 0, 100);
        send(8'h0F, 8'h00, 3'd1, 0, 0, 100);
        send(8'hFF, 8'h00, 3'd1, 0, 0, 100);
        send(8'hFF, 8'h00, 3'd1, 1, 0, 100);
        send(8'h3C, 8'h00, 3'd1, 0, 1, 100);
        @(negedge clk);
        chk("sat_q", 32'(Q), 32'h0C);
        chk("sat_cnt", 32'(cnt), 3);
        @(posedge clk); #1;

        // reset mid-burst
        send(8'h11, 8'h00, 3'd4, 1, 0, 100);
        send(8'h22, 8'h00, 3'd4, 1, 0, 100);
        rst_n = 1'b0;
        in_burst = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_q", 32'(Q), 0);
        chk("midrst_cnt", 32'(cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'hAA, 8'h00, 3'd7, 0, 0, 100);
        @(negedge clk);
        chk("buf_q", 32'(Q), 32'hAA);
        @(posedge clk); #1;

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        send(8'hFF, 8'hFF, 3'd4, 0, 0, 100);
        @(negedge clk);
        chk("flag_zero1", 32'(zero), 1);
        chk("flag_par1", 32'(parity), 0);
        @(posedge clk); #1;
        send(8'h07, 8'h00, 3'd7, 0, 0, 100);
        @(negedge clk);
        chk("flag_zero2", 32'(zero), 0);
        chk("flag_par2", 32'(parity), 1);
        @(posedge clk); #1;
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int idle = $urandom_range(2);
            for (int k = 0; k < idle; k++) begin
                out_ready = $urandom_range(1);
                @(posedge clk); #1;
            end
            send(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(7)),
                 ($urandom_range(99) < 50), ($urandom_range(99) < 30), 70);
        end
        if (in_burst) send(WIDTH'($urandom), 8'h00, 3'd0, 0, 1, 100);

        out_ready = 1'b1;
        for (int t = 0; t < 20 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 0);
        chk("drain_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
